jpc_fetch: RTL and testbench
============================

JPC_FETCH -- requirements
Module: jpc_fetch

Interface
REQ-001 Parameter RESET_PC, default 0, word address loaded into PC on reset.
REQ-002 Data/address width W = `JPC_ADDRESS_WIDTH` for all address, PC and instruction ports.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 mem_addr  output  W  word address to the synchronous instruction RAM.
REQ-006 mem_rdata  input  W  RAM read data, valid the cycle after the address.
REQ-007 redirect_valid  input  1  one-cycle pulse requesting a PC change and pipeline flush.
REQ-008 redirect_pc  input  W  new word address, sampled when redirect_valid=1.
REQ-009 out_valid  output  1  instruction available to decode.
REQ-010 out_ready  input  1  decode accepts; handshake when out_valid and out_ready are both 1.
REQ-011 out_instr  output  W  fetched instruction word.
REQ-012 out_pc  output  W  word address from which out_instr was read.
REQ-013 fetch_count  output  32  accepted-instruction counter; present only with JPC_FETCH_PERF_EN.

Function
REQ-014 Block SHALL hold PC register pc_q, in-flight flag plus its PC, and a 2-entry FIFO of {pc, instr}.
REQ-015 Terms: pop = out_valid & out_ready; issue = !rst & !redirect_valid & (fifo_count + inflight - pop) < 2.
REQ-016 mem_addr SHALL equal pc_q every cycle; RAM reads with no issue are ignored.
REQ-017 On issue: pc_q <= pc_q + 1 modulo 2^W (all-ones wraps to 0); inflight <= 1; inflight_pc <= pc_q.
REQ-018 With no issue, inflight <= 0.
REQ-019 If inflight=1 and no redirect this cycle, the FIFO SHALL push {inflight_pc, mem_rdata} at the cycle end.
REQ-020 Pop and push in the same cycle SHALL both take effect; the credit rule guarantees no overflow.
REQ-021 out_valid = (fifo_count != 0); out_instr/out_pc SHALL show the FIFO head.
REQ-022 While out_valid=1 and out_ready=0, out_instr and out_pc SHALL stay stable.
REQ-023 Steady state with out_ready=1 SHALL give one instruction per cycle with consecutive out_pc.
REQ-024 Latency: issue in cycle C gives push at end of C+1 and out_valid=1 in C+2.
REQ-025 redirect_valid in cycle N has priority over issue and push:
- pc_q <= redirect_pc.
- FIFO cleared; inflight <= 0.
- out_valid=0 in N+1; first issue from redirect_pc in N+1; out_valid in N+3.
REQ-026 A pop coinciding with redirect_valid SHALL count as completed; all other entries are discarded.
REQ-027 Back-to-back redirects: the last one wins, and nothing is issued while redirect_valid=1.
REQ-028 Block SHALL never write memory and SHALL have no other outputs.

Reset
REQ-029 Reset values: pc_q=RESET_PC, mem_addr=RESET_PC, inflight=0, fifo_count=0, out_valid=0, out_instr=0, out_pc=0, fetch_count=0.
REQ-030 Reset SHALL dominate redirect_valid and out_ready, and SHALL discard in-flight and buffered data.
REQ-031 Reset mid-operation: the first cycle with rst=0 SHALL behave exactly like the first cycle after power-on reset.

Configuration
REQ-032 Macro JPC_FETCH_PERF_EN defined: fetch_count increments by 1 on each pop, including a pop in a redirect cycle, and wraps at 2^32.
REQ-033 Macro JPC_FETCH_PERF_EN undefined: fetch_count port and counter logic absent; all other behaviour identical.

Verification
REQ-034 Common setup for all scenarios: W=32, RAM mem[i]=0x1000+i, RESET_PC=0.
REQ-035 Streaming: out_ready=1 held after reset release in cycle C:
- out_valid=1 from C+2.
- out_pc 0,1,2,... and out_instr 0x1000,0x1001,... every cycle.
REQ-036 Backpressure: out_ready=0 for 5 cycles mid-stream:
- out_pc/out_instr frozen.
- After release, the sequence resumes with no skipped or duplicated PC.
REQ-037 Redirect: redirect_valid=1, redirect_pc=0x40 in cycle N:
- out_valid=0 in N+1 and N+2.
- N+3 shows out_pc=0x40, out_instr=0x1040.
REQ-038 Wrap: RESET_PC=0xFFFFFFFF with a model returning 0xAA00+(addr&0xFF): out_pc 0xFFFFFFFF then 0x00000000.
REQ-039 Reset mid-stream at out_pc=7:
- Outputs at reset values during reset.
- After release, stream restarts at out_pc=0.
- With JPC_FETCH_PERF_EN, fetch_count=0 after reset, then equals the accepted count (10 after 10 pops).

Source files
------------

// File: rtl/jpc_fetch.sv
// Instruction fetch stage: credit-based issue to a synchronous RAM, 2-entry skid FIFO to decode.
// Optional accepted-instruction counter enabled by defining JPC_FETCH_PERF_EN.

`ifndef JPC_ADDRESS_WIDTH
`define JPC_ADDRESS_WIDTH 32
`endif

module jpc_fetch #(
  parameter logic [`JPC_ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [`JPC_ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [`JPC_ADDRESS_WIDTH-1:0] mem_rdata,
  input  logic                          redirect_valid,
  input  logic [`JPC_ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [`JPC_ADDRESS_WIDTH-1:0] out_instr,
`ifdef JPC_FETCH_PERF_EN
  output logic [31:0]                   fetch_count,
`endif
  output logic [`JPC_ADDRESS_WIDTH-1:0] out_pc
);

  localparam int unsigned W = `JPC_ADDRESS_WIDTH;

  logic [W-1:0] pc_q, pc_d;
  logic         inflight_q, inflight_d;
  logic [W-1:0] inflight_pc_q, inflight_pc_d;
  logic [W-1:0] head_pc_q, head_pc_d, head_instr_q, head_instr_d;
  logic [W-1:0] tail_pc_q, tail_pc_d, tail_instr_q, tail_instr_d;
  logic [1:0]   count_q, count_d;

  logic         pop, push, issue;
  logic [2:0]   occupancy;

  assign mem_addr  = pc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_pc    = head_pc_q;
  assign out_instr = head_instr_q;

  assign pop       = out_valid & out_ready;
  assign push      = inflight_q & ~redirect_valid;
  // Credits: buffered + in-flight entries after this cycle's pop must leave room for one more.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = ~rst & ~redirect_valid & (occupancy < 3'd2);

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    head_pc_d     = head_pc_q;
    head_instr_d  = head_instr_q;
    tail_pc_d     = tail_pc_q;
    tail_instr_d  = tail_instr_q;
    count_d       = count_q;

    if (redirect_valid) begin
      pc_d    = redirect_pc;
      count_d = 2'd0;
    end else begin
      if (issue) begin
        pc_d          = pc_q + {{(W-1){1'b0}}, 1'b1};
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
      end

      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_pc_d    = inflight_pc_q;
            head_instr_d = mem_rdata;
          end else begin
            tail_pc_d    = inflight_pc_q;
            tail_instr_d = mem_rdata;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_pc_d    = tail_pc_q;
          head_instr_d = tail_instr_q;
          count_d      = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_pc_d    = inflight_pc_q;
            head_instr_d = mem_rdata;
          end else begin
            head_pc_d    = tail_pc_q;
            head_instr_d = tail_instr_q;
            tail_pc_d    = inflight_pc_q;
            tail_instr_d = mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      head_pc_q     <= '0;
      head_instr_q  <= '0;
      tail_pc_q     <= '0;
      tail_instr_q  <= '0;
      count_q       <= 2'd0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_pc_q     <= head_pc_d;
      head_instr_q  <= head_instr_d;
      tail_pc_q     <= tail_pc_d;
      tail_instr_q  <= tail_instr_d;
      count_q       <= count_d;
    end
  end

`ifdef JPC_FETCH_PERF_EN
  logic [31:0] fetch_count_q;

  // A pop in a redirect cycle still completes, so it is counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= 32'd0;
    end else if (pop) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_jpc_fetch.sv
// Directed self-checking bench for jpc_fetch: reset, streaming, backpressure, redirects, wrap.
// Two instances: RESET_PC=0 for most scenarios and RESET_PC=all-ones for the wrap case.

module tb_jpc_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, redirect_valid, out_ready, out_valid;
  logic [31:0] redirect_pc, mem_addr, mem_rdata, out_instr, out_pc;

  logic        w_rst, w_redirect_valid, w_ready, w_valid;
  logic [31:0] w_redirect_pc, w_addr, w_rdata, w_instr, w_pc;

`ifdef JPC_FETCH_PERF_EN
  logic [31:0] fetch_count, w_fetch_count;
`endif

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;

  jpc_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
`ifdef JPC_FETCH_PERF_EN
    .fetch_count   (fetch_count),
`endif
    .out_pc        (out_pc)
  );

  jpc_fetch #(.RESET_PC(32'hFFFF_FFFF)) u_dut_wrap (
    .clk           (clk),
    .rst           (w_rst),
    .mem_addr      (w_addr),
    .mem_rdata     (w_rdata),
    .redirect_valid(w_redirect_valid),
    .redirect_pc   (w_redirect_pc),
    .out_valid     (w_valid),
    .out_ready     (w_ready),
    .out_instr     (w_instr),
`ifdef JPC_FETCH_PERF_EN
    .fetch_count   (w_fetch_count),
`endif
    .out_pc        (w_pc)
  );

  // Synchronous instruction RAM models.
  always_ff @(posedge clk) mem_rdata <= 32'h1000 + mem_addr;
  always_ff @(posedge clk) w_rdata <= 32'hAA00 + (w_addr & 32'h0000_00FF);

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h55; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      tests++; if (out_pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want 0", out_pc); end
      tests++; if (out_instr !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h want 0", out_instr); end
      tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
`ifdef JPC_FETCH_PERF_EN
      tests++; if (fetch_count !== 32'h0) begin fails++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
`endif
    end
    redirect_valid = 1'b0;
  endtask

  // Releases reset in the cycle of the first negedge and streams ten instructions from PC 0.
  task automatic test_stream();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) begin rst = 1'b0; out_ready = 1'b1; end
      if (k < 2) begin
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_lat k=%0d: got %b want 0", k, out_valid); end
      end else begin
        exp_pc = 32'(k - 2);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL stream_valid k=%0d: got %b want 1", k, out_valid); end
        tests++; if (out_pc !== exp_pc) begin fails++; $display("FAIL stream_pc k=%0d: got %h want %h", k, out_pc, exp_pc); end
        tests++; if (out_instr !== 32'h1000 + exp_pc) begin fails++; $display("FAIL stream_instr k=%0d: got %h want %h", k, out_instr, 32'h1000 + exp_pc); end
      end
    end
    exp_pc  = 32'd10;
    exp_cnt = 32'd10;
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid k=%0d: got %b want 1", k, out_valid); end
      tests++; if (out_pc !== exp_pc) begin fails++; $display("FAIL bp_pc k=%0d: got %h want %h", k, out_pc, exp_pc); end
      tests++; if (out_instr !== 32'h1000 + exp_pc) begin fails++; $display("FAIL bp_instr k=%0d: got %h want %h", k, out_instr, 32'h1000 + exp_pc); end
`ifdef JPC_FETCH_PERF_EN
      tests++; if (fetch_count !== exp_cnt) begin fails++; $display("FAIL bp_count k=%0d: got %0d want %0d", k, fetch_count, exp_cnt); end
`endif
      out_ready = (k >= 5);
      if (out_ready) begin exp_pc++; exp_cnt++; end
    end
  endtask

  task automatic test_redirect();
    @(negedge clk);
    tests++; if (out_pc !== exp_pc) begin fails++; $display("FAIL redir_pre_pc: got %h want %h", out_pc, exp_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h40; exp_cnt++;
    @(negedge clk);
    redirect_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL redir_n1_valid: got %b want 0", out_valid); end
    tests++; if (mem_addr !== 32'h40) begin fails++; $display("FAIL redir_n1_addr: got %h want 40", mem_addr); end
`ifdef JPC_FETCH_PERF_EN
    tests++; if (fetch_count !== exp_cnt) begin fails++; $display("FAIL redir_count: got %0d want %0d", fetch_count, exp_cnt); end
`endif
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL redir_n2_valid: got %b want 0", out_valid); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      exp_pc = 32'h40 + 32'(k);
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL redir_valid k=%0d: got %b want 1", k, out_valid); end
      tests++; if (out_pc !== exp_pc) begin fails++; $display("FAIL redir_pc k=%0d: got %h want %h", k, out_pc, exp_pc); end
      tests++; if (out_instr !== 32'h1000 + exp_pc) begin fails++; $display("FAIL redir_instr k=%0d: got %h want %h", k, out_instr, 32'h1000 + exp_pc); end
      exp_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    tests++; if (out_pc !== 32'h43) begin fails++; $display("FAIL b2b_pre_pc: got %h want 43", out_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h80; exp_cnt++;
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_m1_valid: got %b want 0", out_valid); end
    tests++; if (mem_addr !== 32'h80) begin fails++; $display("FAIL b2b_m1_addr: got %h want 80", mem_addr); end
    redirect_pc = 32'h20;
    @(negedge clk);
    redirect_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_m2_valid: got %b want 0", out_valid); end
    tests++; if (mem_addr !== 32'h20) begin fails++; $display("FAIL b2b_m2_addr: got %h want 20", mem_addr); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_m3_valid: got %b want 0", out_valid); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_m4_valid: got %b want 1", out_valid); end
    tests++; if (out_pc !== 32'h20) begin fails++; $display("FAIL b2b_m4_pc: got %h want 20", out_pc); end
    tests++; if (out_instr !== 32'h1020) begin fails++; $display("FAIL b2b_m4_instr: got %h want 1020", out_instr); end
`ifdef JPC_FETCH_PERF_EN
    tests++; if (fetch_count !== exp_cnt) begin fails++; $display("FAIL b2b_count: got %0d want %0d", fetch_count, exp_cnt); end
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL %s_valid: got %b want 0", tag, out_valid); end
    tests++; if (out_pc !== 32'h0) begin fails++; $display("FAIL %s_pc: got %h want 0", tag, out_pc); end
    tests++; if (out_instr !== 32'h0) begin fails++; $display("FAIL %s_instr: got %h want 0", tag, out_instr); end
    tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL %s_addr: got %h want 0", tag, mem_addr); end
`ifdef JPC_FETCH_PERF_EN
    tests++; if (fetch_count !== 32'h0) begin fails++; $display("FAIL %s_count: got %0d want 0", tag, fetch_count); end
`endif
  endtask

  // Reach out_pc=7, reset with out_ready held high, then restart from PC 0.
  task automatic test_reset_mid();
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check_reset_outputs("rmid_pre");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) rst = 1'b0;
      if (k >= 2) begin
        tests++; if (out_pc !== 32'(k - 2)) begin fails++; $display("FAIL rmid_pre_pc k=%0d: got %h want %h", k, out_pc, 32'(k - 2)); end
      end
    end
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_reset_outputs("rmid_during");
    end
    for (int k = 0; k < 13; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) rst = 1'b0;
      if (k < 2) begin
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmid_lat k=%0d: got %b want 0", k, out_valid); end
      end else begin
        exp_pc = 32'(k - 2);
        tests++; if (out_pc !== exp_pc) begin fails++; $display("FAIL rmid_pc k=%0d: got %h want %h", k, out_pc, exp_pc); end
        tests++; if (out_instr !== 32'h1000 + exp_pc) begin fails++; $display("FAIL rmid_instr k=%0d: got %h want %h", k, out_instr, 32'h1000 + exp_pc); end
      end
`ifdef JPC_FETCH_PERF_EN
      if (k == 12) begin
        tests++; if (fetch_count !== 32'd10) begin fails++; $display("FAIL rmid_count: got %0d want 10", fetch_count); end
      end
`endif
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    tests++; if (w_addr !== 32'hFFFF_FFFF) begin fails++; $display("FAIL wrap_reset_addr: got %h want ffffffff", w_addr); end
    tests++; if (w_valid !== 1'b0) begin fails++; $display("FAIL wrap_reset_valid: got %b want 0", w_valid); end
    w_rst = 1'b0;
    @(negedge clk);
    tests++; if (w_addr !== 32'h0) begin fails++; $display("FAIL wrap_addr: got %h want 0", w_addr); end
    @(negedge clk);
    tests++; if (w_valid !== 1'b1) begin fails++; $display("FAIL wrap_valid: got %b want 1", w_valid); end
    tests++; if (w_pc !== 32'hFFFF_FFFF) begin fails++; $display("FAIL wrap_pc0: got %h want ffffffff", w_pc); end
    tests++; if (w_instr !== 32'hAAFF) begin fails++; $display("FAIL wrap_instr0: got %h want aaff", w_instr); end
    @(negedge clk);
    tests++; if (w_pc !== 32'h0) begin fails++; $display("FAIL wrap_pc1: got %h want 0", w_pc); end
    tests++; if (w_instr !== 32'hAA00) begin fails++; $display("FAIL wrap_instr1: got %h want aa00", w_instr); end
    @(negedge clk);
    tests++; if (w_pc !== 32'h1) begin fails++; $display("FAIL wrap_pc2: got %h want 1", w_pc); end
    tests++; if (w_instr !== 32'hAA01) begin fails++; $display("FAIL wrap_instr2: got %h want aa01", w_instr); end
`ifdef JPC_FETCH_PERF_EN
    tests++; if (w_fetch_count !== 32'd2) begin fails++; $display("FAIL wrap_count: got %0d want 2", w_fetch_count); end
`endif
  endtask

  initial begin
    w_rst = 1'b1; w_redirect_valid = 1'b0; w_redirect_pc = 32'h0; w_ready = 1'b1;
    exp_pc = 32'h0; exp_cnt = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
